// File: rtl/axi_slave_bridge_pkg.sv
// Shared types and constants for the AXI slave to DDR2 native-port bridge.
// State encodings, response codes and the burst-size helper live here.
package axi_slave_bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_WCMD,
        S_WFLUSH,
        S_WRESP,
        S_RCMD,
        S_RDATA
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic oversize_len(input logic [7:0] len, input int depth);
        return int'(len) >= depth;
    endfunction

endpackage

// File: rtl/axi_slave_bridge_if.sv
// AXI slave channels plus the native DDR2 core port of the bridge.
// slave: bridge view; master: the AXI master and DDR2 core around it.
interface axi_slave_bridge_if #(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 16
);
    logic                  init_end;
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic                  wvalid;
    logic                  wready;
    logic                  wlast;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic                  rvalid;
    logic                  rready;
    logic                  rlast;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_wr;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [7:0]            cmd_len;
    logic                  wr_data_req;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_data_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  overflow;

    modport slave (
        input  init_end,
        input  awvalid, awaddr, awlen, output awready,
        input  wvalid, wlast, wdata, output wready,
        input  bready, output bvalid, bresp,
        input  arvalid, araddr, arlen, output arready,
        input  rready, output rvalid, rlast, rdata, rresp,
        input  cmd_ready, output cmd_valid, cmd_wr, cmd_addr, cmd_len,
        input  wr_data_req, output wr_data,
        input  rd_data_valid, rd_data,
        output overflow
    );

    modport master (
        output init_end,
        output awvalid, awaddr, awlen, input awready,
        output wvalid, wlast, wdata, input wready,
        output bready, input bvalid, bresp,
        output arvalid, araddr, arlen, input arready,
        output rready, input rvalid, rlast, rdata, rresp,
        output cmd_ready, input cmd_valid, cmd_wr, cmd_addr, cmd_len,
        output wr_data_req, input wr_data,
        output rd_data_valid, rd_data,
        input  overflow
    );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: dout is the head entry whenever !empty.
// flush empties it and wins over a push/pop in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp;
    logic [AW:0]      rp;
    logic             do_push;
    logic             do_pop;

    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty   = (wp == rp);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wp[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push)
                wp <= wp + (AW+1)'(1);
            if (do_pop)
                rp <= rp + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/axi_slave_bridge.sv
// AXI slave to DDR2 native-port bridge: one transaction at a time, write
// beats staged in a FIFO before the command, read beats buffered after it.
module axi_slave_bridge
    import axi_slave_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 16
) (
    input logic               clk,
    input logic               rst,
    axi_slave_bridge_if.slave bus
);
    state_t                state;
    logic                  prefer_wr;
    logic                  oversize;
    logic                  err;
    logic                  overflow;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [8:0]            beat;
    logic [7:0]            cnt;
    logic                  cmd_valid;
    logic                  cmd_wr;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [7:0]            cmd_len;
    logic                  bvalid;
    logic [1:0]            bresp;

    logic                  acc_w;
    logic                  acc_r;
    logic                  w_discard;
    logic                  w_hs;
    logic                  w_bad;
    logic                  w_fail;
    logic                  r_hs;
    logic                  wf_push;
    logic                  wf_pop;
    logic                  wf_flush;
    logic                  wf_full;
    logic                  wf_empty;
    logic [DATA_WIDTH-1:0] wf_head;
    logic                  rf_push;
    logic                  rf_pop;
    logic                  rf_flush;
    logic                  rf_full;
    logic                  rf_empty;
    logic [DATA_WIDTH-1:0] rf_head;

    assign acc_w = (state == S_IDLE) && !rst && bus.init_end && bus.awvalid
                   && (!bus.arvalid || prefer_wr);
    assign acc_r = (state == S_IDLE) && !rst && bus.init_end && bus.arvalid
                   && !acc_w;

    // Beats past awlen (and all beats of an oversize burst) are swallowed.
    assign w_discard = oversize || (beat > {1'b0, len});
    assign w_hs      = bus.wvalid && bus.wready;
    assign w_bad     = bus.wlast ? (beat != {1'b0, len}) : (beat == {1'b0, len});
    assign w_fail    = err || w_bad || oversize;
    assign wf_push   = w_hs && !w_discard;
    assign wf_flush  = w_hs && bus.wlast && w_fail;
    assign wf_pop    = (state == S_WFLUSH) && bus.wr_data_req && !wf_empty;

    assign rf_push  = (state == S_RDATA) && !oversize && bus.rd_data_valid
                      && !rf_full;
    assign r_hs     = bus.rvalid && bus.rready;
    assign rf_pop   = r_hs && !oversize;
    assign rf_flush = r_hs && bus.rlast;

    assign bus.awready   = acc_w;
    assign bus.arready   = acc_r;
    assign bus.wready    = (state == S_WDATA) && bus.init_end
                           && (w_discard || !wf_full);
    assign bus.wr_data   = (state == S_WFLUSH) ? wf_head : '0;
    assign bus.rvalid    = (state == S_RDATA) && (oversize || !rf_empty);
    assign bus.rdata     = ((state == S_RDATA) && !oversize && !rf_empty)
                           ? rf_head : '0;
    assign bus.rresp     = ((state == S_RDATA) && oversize) ? RESP_SLVERR
                                                            : RESP_OKAY;
    assign bus.rlast     = bus.rvalid && (cnt == len);
    assign bus.cmd_valid = cmd_valid;
    assign bus.cmd_wr    = cmd_wr;
    assign bus.cmd_addr  = cmd_addr;
    assign bus.cmd_len   = cmd_len;
    assign bus.bvalid    = bvalid;
    assign bus.bresp     = bresp;
    assign bus.overflow  = overflow;

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_wfifo (
        .clk(clk), .rst(rst), .flush(wf_flush),
        .push(wf_push), .din(bus.wdata), .pop(wf_pop),
        .dout(wf_head), .full(wf_full), .empty(wf_empty)
    );

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rfifo (
        .clk(clk), .rst(rst), .flush(rf_flush),
        .push(rf_push), .din(bus.rd_data), .pop(rf_pop),
        .dout(rf_head), .full(rf_full), .empty(rf_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            prefer_wr <= 1'b1;
            oversize  <= 1'b0;
            err       <= 1'b0;
            overflow  <= 1'b0;
            addr      <= '0;
            len       <= '0;
            beat      <= '0;
            cnt       <= '0;
            cmd_valid <= 1'b0;
            cmd_wr    <= 1'b0;
            cmd_addr  <= '0;
            cmd_len   <= '0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
        end else begin
            if (bus.rd_data_valid && !rf_push)
                overflow <= 1'b1;
            unique case (state)
                S_IDLE: begin
                    if (acc_w) begin
                        addr      <= bus.awaddr;
                        len       <= bus.awlen;
                        oversize  <= oversize_len(bus.awlen, FIFO_DEPTH);
                        err       <= 1'b0;
                        beat      <= '0;
                        prefer_wr <= 1'b0;
                        state     <= S_WDATA;
                    end else if (acc_r) begin
                        len       <= bus.arlen;
                        oversize  <= oversize_len(bus.arlen, FIFO_DEPTH);
                        cnt       <= '0;
                        prefer_wr <= 1'b1;
                        if (oversize_len(bus.arlen, FIFO_DEPTH)) begin
                            state <= S_RDATA;
                        end else begin
                            cmd_valid <= 1'b1;
                            cmd_wr    <= 1'b0;
                            cmd_addr  <= bus.araddr;
                            cmd_len   <= bus.arlen;
                            state     <= S_RCMD;
                        end
                    end
                end
                S_WDATA: begin
                    if (w_hs) begin
                        if (beat != 9'h1ff)
                            beat <= beat + 9'd1;
                        if (w_bad)
                            err <= 1'b1;
                        if (bus.wlast && w_fail) begin
                            bvalid <= 1'b1;
                            bresp  <= RESP_SLVERR;
                            state  <= S_WRESP;
                        end else if (bus.wlast) begin
                            cmd_valid <= 1'b1;
                            cmd_wr    <= 1'b1;
                            cmd_addr  <= addr;
                            cmd_len   <= len;
                            state     <= S_WCMD;
                        end
                    end
                end
                S_WCMD: begin
                    if (bus.cmd_ready) begin
                        cmd_valid <= 1'b0;
                        cnt       <= '0;
                        state     <= S_WFLUSH;
                    end
                end
                S_WFLUSH: begin
                    if (wf_pop) begin
                        cnt <= cnt + 8'd1;
                        if (cnt == len) begin
                            bvalid <= 1'b1;
                            bresp  <= RESP_OKAY;
                            state  <= S_WRESP;
                        end
                    end
                end
                S_WRESP: begin
                    if (bus.bready) begin
                        bvalid <= 1'b0;
                        bresp  <= RESP_OKAY;
                        state  <= S_IDLE;
                    end
                end
                S_RCMD: begin
                    if (bus.cmd_ready) begin
                        cmd_valid <= 1'b0;
                        cnt       <= '0;
                        state     <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (r_hs) begin
                        cnt <= cnt + 8'd1;
                        if (cnt == len)
                            state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
